// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game blocks: colour codes, checker states,
// default sequence length and button-vector helpers.
package simon_pkg;

    localparam int MAX_LEN_DEFAULT = 16;

    localparam logic [1:0] COLOR_0 = 2'b00;
    localparam logic [1:0] COLOR_1 = 2'b01;
    localparam logic [1:0] COLOR_2 = 2'b10;
    localparam logic [1:0] COLOR_3 = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PRESS,
        WAIT_RELEASE,
        PASS,
        FAIL
    } chk_state_e;

    function automatic logic is_single_press(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    // Only meaningful for one-hot inputs; anything else maps to COLOR_0.
    function automatic logic [1:0] encode_button(input logic [3:0] v);
        logic [1:0] code;
        case (v)
            4'b0010: code = COLOR_1;
            4'b0100: code = COLOR_2;
            4'b1000: code = COLOR_3;
            default: code = COLOR_0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus per-bit debounce for the four colour buttons.
// A bit changes only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] buttons,
    output logic [3:0] debounced
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [CNT_W-1:0] cnt [4];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1     <= '0;
            sync2     <= '0;
            debounced <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            sync1 <= buttons;
            sync2 <= sync1;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == debounced[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    debounced[i] <= sync2[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/simon_input_checker.sv
// Player-side sequence checker: debounces buttons, encodes presses to colour
// codes and matches them against the stored sequence. Optional response
// timeout is enabled with `define SIMON_INPUT_TIMEOUT_EN.
module simon_input_checker
    import simon_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_LEN         = MAX_LEN_DEFAULT,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         CheckEnable,
    input  logic [$clog2(MAX_LEN+1)-1:0] SeqLength,
    input  logic [3:0]                   Buttons,
    output logic [$clog2(MAX_LEN)-1:0]   ExpIndex,
    input  logic [1:0]                   ExpColor,
    output logic                         PressValid,
    output logic [1:0]                   PressColor,
    output logic                         Pass,
    output logic                         Fail,
    output logic                         Busy
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    if (DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("simon_input_checker: DEBOUNCE_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    chk_state_e       state;
    chk_state_e       state_next;
    logic [LEN_W-1:0] seq_len;
    logic [3:0]       deb;
    logic [3:0]       deb_prev;
    logic             press_evt;
    logic [1:0]       press_enc;
    logic             last_idx;
    logic             tmo_hit;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .reset    (reset),
        .buttons  (Buttons),
        .debounced(deb)
    );

    // A press is the debounced vector leaving all-released with exactly one bit set.
    assign press_evt = (deb_prev == 4'b0000) && is_single_press(deb);
    assign press_enc = encode_button(deb);
    assign last_idx  = (LEN_W'(ExpIndex) == seq_len - 1'b1);

`ifdef SIMON_INPUT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (state_next != state) begin
            tmo_cnt <= '0;
        end else if (state == WAIT_PRESS || state == WAIT_RELEASE) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (CheckEnable) state_next = (SeqLength == '0) ? PASS : WAIT_PRESS;
            end
            WAIT_PRESS: begin
                if (press_evt) begin
                    if (press_enc != ExpColor) state_next = FAIL;
                    else if (last_idx)         state_next = PASS;
                    else                       state_next = WAIT_RELEASE;
                end else if (tmo_hit) begin
                    state_next = FAIL;
                end
            end
            WAIT_RELEASE: begin
                if (deb == 4'b0000) state_next = WAIT_PRESS;
                else if (tmo_hit)   state_next = FAIL;
            end
            PASS:    state_next = IDLE;
            FAIL:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            seq_len    <= '0;
            ExpIndex   <= '0;
            deb_prev   <= '0;
            PressValid <= 1'b0;
            PressColor <= '0;
        end else begin
            state      <= state_next;
            deb_prev   <= deb;
            PressValid <= press_evt;
            if (press_evt) PressColor <= press_enc;

            if (state == IDLE && CheckEnable) begin
                seq_len  <= (SeqLength > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : SeqLength;
                ExpIndex <= '0;
            end else if (state == WAIT_PRESS && state_next == WAIT_RELEASE) begin
                ExpIndex <= ExpIndex + 1'b1;
            end
        end
    end

    assign Pass = (state == PASS);
    assign Fail = (state == FAIL);
    assign Busy = (state != IDLE);

endmodule

// File: tb/tb_simon_input_checker.sv
// Directed bench for simon_input_checker with a cycle-level behavioural model
// of the debounce window and the player turn, compared on every cycle.
module tb_simon_input_checker;
    localparam int D       = 4;
    localparam int MAXL    = 16;
    localparam int TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       CheckEnable;
    logic [4:0] SeqLength;
    logic [3:0] Buttons;
    logic [3:0] ExpIndex;
    logic [1:0] ExpColor;
    logic       PressValid;
    logic [1:0] PressColor;
    logic       Pass;
    logic       Fail;
    logic       Busy;

    logic [1:0] mem [16];
    assign ExpColor = mem[ExpIndex];

    simon_input_checker #(
        .DEBOUNCE_CYCLES(D),
        .MAX_LEN        (MAXL),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .CheckEnable(CheckEnable),
        .SeqLength  (SeqLength),
        .Buttons    (Buttons),
        .ExpIndex   (ExpIndex),
        .ExpColor   (ExpColor),
        .PressValid (PressValid),
        .PressColor (PressColor),
        .Pass       (Pass),
        .Fail       (Fail),
        .Busy       (Busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s at edge %0d: got %0h, want %0h", name, cyc, got, want);
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0] m_s1, m_s2, m_deb, m_deb_prev, m_new_deb;
    logic [3:0] hist [$];
    logic       m_pv, m_pass, m_fail, m_active, m_wrel, m_press, m_changed, all_diff;
    logic [1:0] m_pc, m_enc;
    int         m_len, m_idx, m_tmo;

    function automatic logic [1:0] enc_of(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
        return 2'b00;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0; m_deb_prev = '0; hist.delete();
            m_pv = 0; m_pc = 0; m_pass = 0; m_fail = 0; m_active = 0; m_wrel = 0;
            m_len = 0; m_idx = 0; m_tmo = 0;
        end else begin
            m_press = (m_deb_prev == 4'b0000) && ($countones(m_deb) == 1);
            m_enc   = enc_of(m_deb);
            if (m_pass || m_fail) begin
                m_pass = 0; m_fail = 0;
            end else if (!m_active) begin
                if (CheckEnable) begin
                    m_len = (SeqLength > MAXL) ? MAXL : int'(SeqLength);
                    m_idx = 0;
                    if (m_len == 0) m_pass = 1;
                    else begin m_active = 1; m_wrel = 0; m_tmo = 0; end
                end
            end else begin
                m_changed = 0;
                if (!m_wrel) begin
                    if (m_press) begin
                        m_changed = 1;
                        if (m_enc != mem[m_idx]) begin m_active = 0; m_fail = 1; end
                        else if (m_idx == m_len - 1) begin m_active = 0; m_pass = 1; end
                        else begin m_idx++; m_wrel = 1; end
                    end
                end else if (m_deb == 4'b0000) begin
                    m_wrel = 0; m_changed = 1;
                end
`ifdef SIMON_INPUT_TIMEOUT_EN
                if (m_changed) m_tmo = 0;
                else if (m_tmo == TIMEOUT - 1) begin m_active = 0; m_fail = 1; end
                else m_tmo++;
`endif
            end
            m_pv = m_press;
            if (m_press) m_pc = m_enc;
            // debounced bit flips once the last D synchronized samples all disagree with it
            hist.push_back(m_s2);
            if (hist.size() > D) void'(hist.pop_front());
            m_new_deb = m_deb;
            for (int b = 0; b < 4; b++) begin
                all_diff = (hist.size() == D);
                foreach (hist[i]) if (hist[i][b] == m_deb[b]) all_diff = 0;
                if (all_diff) m_new_deb[b] = ~m_deb[b];
            end
            m_deb_prev = m_deb;
            m_deb      = m_new_deb;
            m_s2       = m_s1;
            m_s1       = Buttons;
        end
    end

    always @(negedge clk) begin
        if (!reset)
            check("reset_outputs", {ExpIndex, PressValid, PressColor, Pass, Fail, Busy}, '0);
        else
            check("model_outputs", {ExpIndex, PressValid, PressColor, Pass, Fail, Busy},
                  {m_idx[3:0], m_pv, m_pc, m_pass, m_fail, m_active | m_pass | m_fail});
    end

    // ---------------- event observer ----------------
    int   pv_n, pv_first, pass_n, pass_cyc, fail_n, fail_cyc;
    logic [3:0] fail_idx;
    logic fail_pv, busy_at_pass, busy_after_pass;
    int   idx_seen [$];

    always @(negedge clk) begin
        if (reset) begin
            if (PressValid) begin pv_n++; if (pv_first < 0) pv_first = cyc; end
            if (Pass) begin pass_n++; pass_cyc = cyc; busy_at_pass = Busy; end
            if (Fail) begin fail_n++; fail_cyc = cyc; fail_idx = ExpIndex; fail_pv = PressValid; end
            if (pass_n > 0 && cyc == pass_cyc + 1) busy_after_pass = Busy;
            if (Busy && (idx_seen.size() == 0 || idx_seen[$] != int'(ExpIndex)))
                idx_seen.push_back(int'(ExpIndex));
        end
    end

    task automatic clear_obs();
        pv_n = 0; pv_first = -1; pass_n = 0; pass_cyc = -10; fail_n = 0; fail_cyc = -10;
        fail_idx = '0; fail_pv = 0; busy_at_pass = 0; busy_after_pass = 1; idx_seen.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic start_turn(input logic [4:0] len);
        SeqLength = len; CheckEnable = 1'b1;
        tick(1);
        CheckEnable = 1'b0;
    endtask

    task automatic press_mask(input logic [3:0] m);
        Buttons = m;
        tick(9);
        Buttons = 4'b0000;
        tick(9);
    endtask

    int ce_edge;

    initial begin
        reset = 1'b0; CheckEnable = 1'b0; SeqLength = '0; Buttons = '0;
        for (int i = 0; i < 16; i++) mem[i] = 2'b00;
        clear_obs();
        tick(2);
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {ExpIndex, PressValid, PressColor, Pass, Fail, Busy}, '0);

        // press latency: stable from edge 10, pulse at edge 16 only
        while (cyc < 9) tick(1);
        clear_obs();
        Buttons = 4'b0100;
        repeat (14) @(negedge clk);
        check("press_edge", pv_first, 16);
        check("press_single_pulse", pv_n, 1);
        check("press_color", PressColor, 2'b10);
        tick(1);
        Buttons = 4'b0000;
        tick(10);

        // three-cycle glitch is filtered
        clear_obs();
        Buttons = 4'b0001;
        tick(3);
        Buttons = 4'b0000;
        tick(12);
        check("glitch_no_press", pv_n, 0);

        // full match of {01,11,00}
        mem[0] = 2'b01; mem[1] = 2'b11; mem[2] = 2'b00;
        clear_obs();
        start_turn(5'd3);
        press_mask(4'b0010);
        press_mask(4'b1000);
        press_mask(4'b0001);
        tick(2);
        check("match_pass_count", pass_n, 1);
        check("match_fail_count", fail_n, 0);
        check("match_idx_steps", idx_seen.size(), 3);
        for (int i = 0; i < 3 && i < idx_seen.size(); i++) check("match_idx_value", idx_seen[i], i);
        check("match_busy_on_pass", busy_at_pass, 1);
        check("match_busy_after_pass", busy_after_pass, 0);

        // mismatch on the second colour
        clear_obs();
        start_turn(5'd3);
        press_mask(4'b0010);
        press_mask(4'b0100);
        check("mismatch_fail_count", fail_n, 1);
        check("mismatch_fail_with_press", fail_pv, 1);
        check("mismatch_fail_idx", fail_idx, 4'd1);
        check("mismatch_no_pass", pass_n, 0);
        check("mismatch_idx_held", ExpIndex, 4'd1);

        // two buttons together, then a valid press, then reset mid-turn
        clear_obs();
        start_turn(5'd3);
        press_mask(4'b0011);
        check("chord_no_press", pv_n, 0);
        check("chord_still_busy", Busy, 1);
        press_mask(4'b0010);
        check("chord_then_match_idx", ExpIndex, 4'd1);
        Buttons = 4'b1000;
        tick(3);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(15);
        Buttons = 4'b0000;
        tick(10);
        check("abort_no_pass", pass_n, 0);
        check("abort_no_fail", fail_n, 0);
        check("abort_idle", Busy, 0);

        // over-long length saturates to 16; CheckEnable mid-turn ignored
        for (int i = 0; i < 16; i++) mem[i] = 2'(i % 4);
        clear_obs();
        start_turn(5'd31);
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                SeqLength = 5'd0; CheckEnable = 1'b1;
                tick(1);
                CheckEnable = 1'b0;
            end
            press_mask(4'(1 << (i % 4)));
        end
        check("sat_pass_count", pass_n, 1);
        check("sat_fail_count", fail_n, 0);
        check("sat_final_idx", ExpIndex, 4'd15);

        // zero-length round passes immediately
        clear_obs();
        ce_edge = cyc + 1;
        start_turn(5'd0);
        tick(3);
        check("zero_len_pass_count", pass_n, 1);
        check("zero_len_pass_edge", pass_cyc, ce_edge);
        check("zero_len_busy_on_pass", busy_at_pass, 1);

`ifdef SIMON_INPUT_TIMEOUT_EN
        clear_obs();
        ce_edge = cyc + 1;
        start_turn(5'd1);
        tick(TIMEOUT + 6);
        check("timeout_fail_count", fail_n, 1);
        check("timeout_fail_edge", fail_cyc, ce_edge + TIMEOUT);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/simon_input_checker.md
Name: simon_input_checker

Overview:
- Player-side counterpart of the colour display block: captures player button presses, encodes each press to the 2-bit colour code, and checks it against the stored sequence.
- Reads expected colours from the sequence memory by index, the same way the display block does.
- Reports pass or fail per round to the game controller.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronized samples required to accept a button change (the board build overrides this to 1000000).
- MAX_LEN, 16, maximum sequence length supported.
- TIMEOUT_CYCLES, 64, player response window in clocks; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- CheckEnable  in  1  one-cycle pulse that starts a player turn.
- SeqLength  in  $clog2(MAX_LEN+1)  number of colours to check this round; sampled on CheckEnable.
- Buttons  in  4  raw, asynchronous push buttons; bit n = colour n.
- ExpIndex  out  $clog2(MAX_LEN)  index of the expected colour.
- ExpColor  in  2  colour at ExpIndex; combinational, valid in the same cycle.
- PressValid  out  1  one-cycle pulse per accepted press.
- PressColor  out  2  encoded colour; held from PressValid until the next press.
- Pass  out  1  one-cycle pulse when the whole sequence has been matched.
- Fail  out  1  one-cycle pulse on mismatch (or timeout).
- Busy  out  1  high from the cycle after CheckEnable until the Pass/Fail cycle inclusive.

Behaviour:
- Reset (asynchronous assert, synchronous deassert use):
  - all outputs 0, ExpIndex 0, state IDLE.
  - synchronizers and debounce counters cleared; debounced vector 0.
- Input path:
  - Buttons pass through a 2-flop synchronizer per bit.
  - Each bit has a counter; the debounced bit takes the synchronized value after DEBOUNCE_CYCLES consecutive cycles of disagreement with its current value.
  - Any agreeing sample resets that bit's counter.
- Press event: debounced vector goes from 4'b0000 to exactly one bit set.
  - Encoding: bit0→00, bit1→01, bit2→10, bit3→11.
  - Two or more bits set: no event; the checker waits for all-released.
  - Latency: Buttons stable high at edge k gives PressValid at edge k+2+DEBOUNCE_CYCLES.
- Debounce and encoding run in every state; PressValid/PressColor are reported even in IDLE.
- State machine:
  - IDLE: on CheckEnable, latch SeqLength and clear ExpIndex. If SeqLength==0 go to PASS, else WAIT_PRESS.
  - WAIT_PRESS: on a press event compare PressColor with ExpColor in the same cycle.
    - Mismatch → FAIL.
    - Match with ExpIndex==SeqLength-1 → PASS.
    - Match otherwise → increment ExpIndex, go to WAIT_RELEASE.
  - WAIT_RELEASE: when the debounced vector is 0 → WAIT_PRESS. Presses before release are impossible by the event definition.
  - PASS / FAIL: assert Pass / Fail for one cycle, then IDLE. ExpIndex is held until the next CheckEnable.
- CheckEnable while Busy is ignored.
- SeqLength > MAX_LEN is saturated to MAX_LEN.
- Reset asserted mid-turn aborts the turn: no Pass or Fail is emitted.
- A press event and CheckEnable in the same IDLE cycle: the press is not checked.

Optional Feature:
- Macro: SIMON_INPUT_TIMEOUT_EN.
- Defined: a counter runs in WAIT_PRESS and WAIT_RELEASE and is cleared on each state entry. Reaching TIMEOUT_CYCLES → FAIL.
- Undefined: no counter; the player may wait indefinitely, and TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package (simon_pkg):
  - colour code constants COLOR_0..COLOR_3 (2-bit).
  - checker state enum {IDLE, WAIT_PRESS, WAIT_RELEASE, PASS, FAIL}.
  - MAX_LEN default, reused by the display block and the sequence memory.
- Sub-module button_debounce: 4-bit synchronizer plus per-bit debounce, parameter DEBOUNCE_CYCLES.
  - Instantiated once.
  - Output: debounced 4-bit vector.

Test Plan (DEBOUNCE_CYCLES=4, MAX_LEN=16):
- Reset held low 2 cycles, then released → all outputs 0, ExpIndex=0, Busy=0.
- Buttons=4'b0100 raised at edge 10 and held → PressValid exactly at edge 16, PressColor=2'b10; no second pulse while held.
- Glitch: Buttons=4'b0001 for 3 cycles, then 0 → no PressValid.
- SeqLength=3 with memory {01,11,00}; presses bit1, bit3, bit0 with releases → ExpIndex steps 0,1,2; single Pass pulse; Busy falls the cycle after Pass.
- Same memory; presses bit1 then bit2 → Fail pulse on the second PressValid cycle; ExpIndex=1.
- Buttons=4'b0011 together → no PressValid, state stays WAIT_PRESS.
- With SIMON_INPUT_TIMEOUT_EN and TIMEOUT_CYCLES=64: CheckEnable with no press → Fail 64 cycles after entering WAIT_PRESS.
- Reset pulsed mid-turn → no Pass or Fail emitted.
